// File: rtl/denormshift_pkg.sv
// Shared types and sizing helpers for the iterative denormalizing right shifter.
// Optional build macro used by this block: DENORMSHIFT_SATURATE_EN.
package denormshift_pkg;

  // Configuration record: data width and shift-amount width.
  typedef struct packed {
    int NORMSHIFTSZ;
    int LOGNORMSHIFTSZ;
  } cvw_t;

  // 16-bit significand; a 5-bit amount reaches past the full width.
  localparam cvw_t CVW_DEFAULT = '{NORMSHIFTSZ: 16, LOGNORMSHIFTSZ: 5};

  typedef enum logic [1:0] {DS_IDLE, DS_SHIFT, DS_DONE} denormshift_state_t;

  // The remaining-distance counter must hold NORMSHIFTSZ itself, hence one extra bit.
  function automatic int ds_rem_width(input cvw_t p);
    return p.LOGNORMSHIFTSZ + 1;
  endfunction

  localparam int DS_REM_W = ds_rem_width(CVW_DEFAULT);

endpackage

// File: rtl/denormshift_if.sv
// Operand/result handshake bundle for denormshift.
// The master offers operands and consumes results; the slave is the shifter.
interface denormshift_if import denormshift_pkg::*; #(
  parameter cvw_t P = CVW_DEFAULT
);
  logic                        InValid;
  logic                        InReady;
  logic [P.NORMSHIFTSZ-1:0]    ShiftIn;
  logic [P.LOGNORMSHIFTSZ-1:0] ShiftAmt;
  logic                        OutValid;
  logic                        OutReady;
  logic [P.NORMSHIFTSZ-1:0]    Shifted;
  logic                        Sticky;

  modport master (
    output InValid, ShiftIn, ShiftAmt, OutReady,
    input  InReady, OutValid, Shifted, Sticky
  );

  modport slave (
    input  InValid, ShiftIn, ShiftAmt, OutReady,
    output InReady, OutValid, Shifted, Sticky
  );
endinterface

// File: rtl/denormshift_step.sv
// One combinational right-shift step of at most STEP bits with sticky collection.
// k may be any value 0..STEP; bits falling off the LSB end are ORed into sticky.
module denormshift_step #(
  parameter int W    = 16,
  parameter int STEP = 8
) (
  input  logic [W-1:0]              data,
  input  logic [$clog2(STEP):0]     k,
  input  logic                      sticky_in,
  output logic [W-1:0]              data_out,
  output logic                      sticky_out
);
  // Mask of the low k bits, i.e. the bits about to be shifted out.
  logic [W-1:0] lost_mask;

  for (genvar gi = 0; gi < W; gi++) begin : g_mask
    assign lost_mask[gi] = (32'(k) > gi);
  end

  assign data_out   = data >> k;
  assign sticky_out = sticky_in | (|(data & lost_mask));
endmodule

// File: rtl/denormshift.sv
// Iterative denormalizer: ShiftIn >> ShiftAmt (logical) with sticky OR of the
// dropped bits, at most STEP bits per cycle, one operation in flight.
// Build macro DENORMSHIFT_SATURATE_EN: amounts >= NORMSHIFTSZ complete on the
// accept edge instead of iterating (same result, shorter latency).
module denormshift import denormshift_pkg::*; #(
  parameter cvw_t P    = CVW_DEFAULT,
  parameter int   STEP = 8
) (
  input logic          clk,
  input logic          reset_n,
  input logic          Flush,
  denormshift_if.slave bus
);
  localparam int W    = P.NORMSHIFTSZ;
  localparam int REMW = ds_rem_width(P);
  localparam int KW   = $clog2(STEP) + 1;

  localparam logic [REMW-1:0] W_R    = REMW'(W);
  localparam logic [REMW-1:0] STEP_R = REMW'(STEP);

  denormshift_state_t state_reg, state_next;
  logic [W-1:0]    data_reg, data_next, step_data;
  logic [REMW-1:0] rem_reg, rem_next, amt_clamped;
  logic            sticky_reg, sticky_next, step_sticky;
  logic [KW-1:0]   step_k;

  // Clamp the requested distance to the data width and pick this cycle's step size.
  always_comb begin
    amt_clamped = ({1'b0, bus.ShiftAmt} > W_R) ? W_R : {1'b0, bus.ShiftAmt};
    step_k      = (rem_reg < STEP_R) ? KW'(rem_reg) : KW'(STEP);
  end

  denormshift_step #(.W(W), .STEP(STEP)) u_step (
    .data       (data_reg),
    .k          (step_k),
    .sticky_in  (sticky_reg),
    .data_out   (step_data),
    .sticky_out (step_sticky)
  );

  // Next-state and datapath update; Flush overrides accept and handover.
  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    rem_next    = rem_reg;
    sticky_next = sticky_reg;
    case (state_reg)
      DS_IDLE: begin
        if (bus.InValid) begin
          data_next   = bus.ShiftIn;
          sticky_next = 1'b0;
          rem_next    = amt_clamped;
          state_next  = (amt_clamped == '0) ? DS_DONE : DS_SHIFT;
`ifdef DENORMSHIFT_SATURATE_EN
          if (amt_clamped == W_R) begin
            data_next   = '0;
            sticky_next = |bus.ShiftIn;
            rem_next    = '0;
            state_next  = DS_DONE;
          end
`else
`endif
        end
      end
      DS_SHIFT: begin
        data_next   = step_data;
        sticky_next = step_sticky;
        rem_next    = rem_reg - REMW'(step_k);
        if (rem_next == '0) begin
          state_next = DS_DONE;
        end
      end
      DS_DONE: begin
        if (bus.OutReady) begin
          state_next = DS_IDLE;
        end
      end
      default: state_next = DS_IDLE;
    endcase
    if (Flush) begin
      state_next  = DS_IDLE;
      sticky_next = 1'b0;
    end
  end

  // State and datapath registers with asynchronous return to the idle values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= DS_IDLE;
      data_reg   <= '0;
      rem_reg    <= '0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      rem_reg    <= rem_next;
      sticky_reg <= sticky_next;
    end
  end

  assign bus.InReady  = (state_reg == DS_IDLE);
  assign bus.OutValid = (state_reg == DS_DONE);
  assign bus.Shifted  = data_reg;
  assign bus.Sticky   = sticky_reg;
endmodule

// File: tb/tb_denormshift.sv
// Directed and randomized checks of denormshift (NORMSHIFTSZ=16, STEP=8).
module tb_denormshift import denormshift_pkg::*;;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  int   checks_total = 0;
  int   checks_passed = 0;

  denormshift_if #(.P(CVW_DEFAULT)) bus ();

  denormshift #(.P(CVW_DEFAULT), .STEP(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from accept (counted as 1) until OutValid is seen.
  function automatic int ref_latency(input logic [4:0] amt);
    int m;
    m = (amt > 5'd16) ? 16 : int'(amt);
`ifdef DENORMSHIFT_SATURATE_EN
    if (amt >= 5'd16) return 1;
`else
`endif
    return 1 + (m + 7) / 8;
  endfunction

  // One full transaction: offer, wait for result, stall, hand over.
  task automatic run_op(input string tag, input logic [15:0] din, input logic [4:0] amt,
                        input int stall, input logic [15:0] exp_shifted,
                        input logic exp_sticky, input int exp_n, input bit verbose);
    int n;
    check({tag, ".inready"}, 32'(bus.InReady), 32'd1);
    bus.InValid  = 1'b1;
    bus.ShiftIn  = din;
    bus.ShiftAmt = amt;
    bus.OutReady = 1'b0;
    tick();
    bus.InValid = 1'b0;
    n = 1;
    while (!bus.OutValid && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_n));
    for (int s = 0; s < stall; s++) begin
      check({tag, ".held_data"}, 32'(bus.Shifted), 32'(exp_shifted));
      check({tag, ".held_sticky"}, 32'(bus.Sticky), 32'(exp_sticky));
      check({tag, ".busy"}, 32'(bus.InReady), 32'd0);
      tick();
    end
    bus.OutReady = 1'b1;
    check({tag, ".outvalid"}, 32'(bus.OutValid), 32'd1);
    check({tag, ".shifted"}, 32'(bus.Shifted), 32'(exp_shifted));
    check({tag, ".sticky"}, 32'(bus.Sticky), 32'(exp_sticky));
    tick();
    bus.OutReady = 1'b0;
    check({tag, ".released"}, 32'(bus.OutValid), 32'd0);
    check({tag, ".idle"}, 32'(bus.InReady), 32'd1);
    if (verbose)
      $display("op %s: in=%04h amt=%0d -> shifted=%04h sticky=%0b latency=%0d",
               tag, din, amt, exp_shifted, exp_sticky, n);
  endtask

  initial begin
    logic [15:0] din, es;
    logic [4:0]  amt;
    logic [31:0] lost;
    logic        est;

    bus.InValid  = 1'b0;
    bus.ShiftIn  = '0;
    bus.ShiftAmt = '0;
    bus.OutReady = 1'b0;

    // Reset values while reset_n is held low.
    tick();
    tick();
    check("reset.inready", 32'(bus.InReady), 32'd1);
    check("reset.outvalid", 32'(bus.OutValid), 32'd0);
    check("reset.shifted", 32'(bus.Shifted), 32'd0);
    check("reset.sticky", 32'(bus.Sticky), 32'd0);
    reset_n = 1'b1;
    tick();

    // 0x0016 >> 3: 10110 -> 10, dropped 110.
    run_op("small", 16'h0016, 5'd3, 0, 16'h0002, 1'b1, 2, 1'b1);
    // 0x8100 >> 9: bit 15 lands on bit 6; bit 8 falls off the end.
    run_op("multi", 16'h8100, 5'd9, 0, 16'h0040, 1'b1, 3, 1'b1);
    // Oversize distance clears the value and keeps the lone set bit as sticky.
`ifdef DENORMSHIFT_SATURATE_EN
    run_op("oversize", 16'h0001, 5'd20, 0, 16'h0000, 1'b1, 1, 1'b1);
`else
    run_op("oversize", 16'h0001, 5'd20, 0, 16'h0000, 1'b1, 3, 1'b1);
`endif
    // Exactly the width takes the same path as oversize.
    run_op("full", 16'h8000, 5'd16, 0, 16'h0000, 1'b1, ref_latency(5'd16), 1'b1);
    // One short of the width leaves only the MSB.
    run_op("w_minus1", 16'h8000, 5'd15, 0, 16'h0001, 1'b0, 3, 1'b1);
    // Exactly one step.
    run_op("one_step", 16'h12FF, 5'd8, 0, 16'h0012, 1'b1, 2, 1'b1);
    // Zero distance with five cycles of backpressure.
    run_op("zero_bp", 16'hBEEF, 5'd0, 5, 16'hBEEF, 1'b0, 1, 1'b1);

    // Flush in the first SHIFT cycle discards the operation.
    bus.InValid  = 1'b1;
    bus.ShiftIn  = 16'hFFFF;
    bus.ShiftAmt = 5'd12;
    tick();
    bus.InValid = 1'b0;
    check("flush.busy", 32'(bus.InReady), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.inready", 32'(bus.InReady), 32'd1);
    check("flush.outvalid", 32'(bus.OutValid), 32'd0);
    check("flush.sticky", 32'(bus.Sticky), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush.quiet", 32'(bus.OutValid), 32'd0);
    end
    $display("op flush: amt=12 discarded in first shift cycle");

    // Flush beats a simultaneous offer.
    bus.InValid = 1'b1;
    flush = 1'b1;
    tick();
    bus.InValid = 1'b0;
    flush = 1'b0;
    check("flush_accept.inready", 32'(bus.InReady), 32'd1);
    tick();
    check("flush_accept.outvalid", 32'(bus.OutValid), 32'd0);
    $display("op flush_accept: offer suppressed");

    // Reset pulsed in the middle of a SHIFT cycle.
    bus.InValid  = 1'b1;
    bus.ShiftIn  = 16'hFFFF;
    bus.ShiftAmt = 5'd12;
    tick();
    bus.InValid = 1'b0;
    tick();
    check("rst_mid.sticky_pre", 32'(bus.Sticky), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid.inready", 32'(bus.InReady), 32'd1);
    check("rst_mid.outvalid", 32'(bus.OutValid), 32'd0);
    check("rst_mid.shifted", 32'(bus.Shifted), 32'd0);
    check("rst_mid.sticky", 32'(bus.Sticky), 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    check("rst_mid.after", 32'(bus.OutValid), 32'd0);
    $display("op rst_mid: async reset during shift");
    run_op("recover", 16'hA5A5, 5'd4, 1, 16'h0A5A, 1'b1, 2, 1'b1);

    // Randomized operands against a reference shift/sticky model.
    for (int t = 0; t < 10000; t++) begin
      din  = 16'($urandom);
      amt  = 5'($urandom_range(0, 31));
      lost = (amt >= 5'd16) ? 32'(din) : (32'(din) & ((32'd1 << amt) - 32'd1));
      es   = (amt >= 5'd16) ? 16'h0000 : (din >> amt);
      est  = |lost;
      run_op("rand", din, amt, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             es, est, ref_latency(amt), 1'b0);
    end
    $display("op rand: 10000 random transactions done");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
